// File: rtl/fb_port_arbiter.sv
// Framebuffer port arbiter: scan-out reads own the RAM port while display_en is
// high; two writer clients share it round-robin during blanking.
module fb_port_arbiter #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int ADDR_W        = 19,
  parameter int DATA_W        = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  display_en,
  input  logic [9:0]            xcoord,
  input  logic [9:0]            ycoord,
  input  logic [1:0]            wr_req,
  input  logic [2*ADDR_W-1:0]   wr_addr,
  input  logic [2*DATA_W-1:0]   wr_data,
  output logic [1:0]            wr_gnt,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [DATA_W-1:0]     pix_data,
  output logic                  pix_valid,
  output logic [7:0]            drop_cnt
);

  localparam logic [ADDR_W:0] FB_SIZE = (ADDR_W+1)'(SCREEN_WIDTH * SCREEN_HEIGHT);

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_SCAN  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_e;

  slot_e               slot_s;
  logic [1:0]          elig_s;
  logic                pick_s;
  logic                in_range_s;
  logic [ADDR_W-1:0]   scan_addr_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic                rr_ptr_r;
  logic                scan_d1_r;
  logic                scan_d2_r;

  assign scan_addr_s = ADDR_W'(ycoord) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(xcoord);

  // Per-cycle slot decision; a client granted last cycle sits out this one.
  always_comb begin
    elig_s = wr_req & ~wr_gnt;
    slot_s = SLOT_IDLE;
    pick_s = 1'b0;
    if (display_en) begin
      slot_s = SLOT_SCAN;
    end else if (elig_s != 2'b00) begin
      slot_s = SLOT_WRITE;
      if (elig_s == 2'b11) begin
        pick_s = rr_ptr_r;
      end else begin
        pick_s = elig_s[1];
      end
    end else begin
      slot_s = SLOT_IDLE;
    end
    sel_addr_s = pick_s ? wr_addr[2*ADDR_W-1:ADDR_W] : wr_addr[ADDR_W-1:0];
    sel_data_s = pick_s ? wr_data[2*DATA_W-1:DATA_W] : wr_data[DATA_W-1:0];
    in_range_s = ({1'b0, sel_addr_s} < FB_SIZE);
  end

  // Registered RAM port, grants, pixel pipeline and drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= {ADDR_W{1'b0}};
      mem_we    <= 1'b0;
      mem_wdata <= {DATA_W{1'b0}};
      wr_gnt    <= 2'b00;
      pix_data  <= {DATA_W{1'b0}};
      pix_valid <= 1'b0;
      scan_d1_r <= 1'b0;
      scan_d2_r <= 1'b0;
      drop_cnt  <= 8'd0;
      rr_ptr_r  <= 1'b0;
    end else begin
      scan_d1_r <= (slot_s == SLOT_SCAN);
      scan_d2_r <= scan_d1_r;
      pix_valid <= scan_d2_r;
      pix_data  <= scan_d2_r ? mem_rdata : {DATA_W{1'b0}};
      case (slot_s)
        SLOT_SCAN: begin
          mem_addr <= scan_addr_s;
          mem_we   <= 1'b0;
          wr_gnt   <= 2'b00;
        end
        SLOT_WRITE: begin
          mem_addr  <= sel_addr_s;
          mem_wdata <= sel_data_s;
          mem_we    <= in_range_s;
          wr_gnt    <= pick_s ? 2'b10 : 2'b01;
          rr_ptr_r  <= ~pick_s;
          // Out-of-range writes are still granted so the client can move on.
          if (!in_range_s && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
        end
        default: begin
          mem_we <= 1'b0;
          wr_gnt <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

- Shares a single-port synchronous framebuffer RAM between the VGA scan-out read path and two game-side writer clients (player/scene draw engines).
- Sits between the VGA timing generator (consumes `display_en`, `xcoord`, `ycoord`) and the framebuffer RAM.
- The scan read has absolute priority during the active region. Writers are served round-robin during blanking.
- Also produces the registered pixel stream for the DAC.

## Interface
Parameters:
- `SCREEN_WIDTH`, 640, pixels per line; address stride.
- `SCREEN_HEIGHT`, 480, visible lines.
- `ADDR_W`, 19, framebuffer address width; must hold `SCREEN_WIDTH*SCREEN_HEIGHT-1`.
- `DATA_W`, 8, pixel width.

Ports:
- `clk`  in  1  pixel clock.
- `reset`  in  1  asynchronous, active-low.
- `display_en`  in  1  active-region flag from the timing generator.
- `xcoord`, `ycoord`  in  10 each  active-region pixel coordinates.
- `wr_req`  in  2  per-client write request; level; bit i = client i.
- `wr_addr`  in  2*ADDR_W  client i address at `[i*ADDR_W +: ADDR_W]`.
- `wr_data`  in  2*DATA_W  client i data at `[i*DATA_W +: DATA_W]`.
- `wr_gnt`  out  2  one-cycle acceptance pulse per client.
- `mem_addr`  out  ADDR_W  RAM address; registered.
- `mem_we`  out  1  RAM write enable; registered.
- `mem_wdata`  out  DATA_W  RAM write data; registered.
- `mem_rdata`  in  DATA_W  RAM read data; valid the cycle after the address is presented.
- `pix_data`  out  DATA_W  pixel to DAC; registered.
- `pix_valid`  out  1  qualifies `pix_data`.
- `drop_cnt`  out  8  saturating count of out-of-range writes.

## Operation
- The per-cycle slot decision is made at cycle N from the inputs sampled at N. It is registered onto `mem_*` and `wr_gnt` at N+1.
- States, recomputed every cycle:
  - SCAN: `display_en=1`.
    - `mem_addr <= ycoord*SCREEN_WIDTH + xcoord`, truncated to ADDR_W. With defaults: `(ycoord<<9)+(ycoord<<7)+xcoord`.
    - `mem_we <= 0`. No grant issued.
  - WRITE: `display_en=0` and at least one eligible request. The chosen client i is granted:
    - `mem_addr <= wr_addr[i]`, `mem_wdata <= wr_data[i]`, `wr_gnt[i] <= 1`.
    - `mem_we <= 1` only if `wr_addr[i] < SCREEN_WIDTH*SCREEN_HEIGHT`. Otherwise `mem_we <= 0` and `drop_cnt` increments, saturating at 255. The grant is still given, so the client never deadlocks.
  - IDLE: `display_en=0`, no eligible request. `mem_we <= 0`, `mem_addr` holds.
- Eligibility: a client whose `wr_gnt` bit is 1 in cycle N is not eligible in cycle N. This prevents a double write of the held request.
  - A single streaming client gets at most 1 write per 2 cycles.
- Round-robin:
  - `rr_ptr` is 1 bit, reset 0.
  - Both eligible: grant client `rr_ptr`.
  - One eligible: grant it.
  - After any grant to client i, `rr_ptr <= ~i`.
- Client rule: hold `wr_req`/`wr_addr`/`wr_data` stable until `wr_gnt[i]` is seen. It may drop or advance in the cycle after `wr_gnt`.
- `wr_gnt` is never asserted while the decision cycle had `display_en=1`. A request pending at the `display_en` rising edge waits for the next blanking interval.
- Read-data path:
  - `scan_d1` and `scan_d2` delay the SCAN flag.
  - `pix_data <= scan_d2 ? mem_rdata : 0`.
  - `pix_valid <= scan_d2`.
- Outputs are 0 during blanking.

## Timing
- Scan latency: coordinates at N → `mem_addr` at N+1 → `mem_rdata` at N+2 → `pix_data`/`pix_valid` at N+3. Fixed 3 cycles; the integrator compensates sync delay.
- Write latency: request sampled at N → `mem_we` and `wr_gnt` at N+1. The RAM commits at the N+1→N+2 edge.
- Reset (asynchronous, any time, including mid-write) clears:
  - `mem_we`, `mem_addr`, `mem_wdata`, `wr_gnt`.
  - `pix_data`, `pix_valid`, `scan_d1`, `scan_d2`.
  - `drop_cnt`, `rr_ptr`.
- After reset, the first edge resumes normal decisions. Ungranted requests are simply re-sampled.
- A write in flight at assertion of reset is abandoned: `mem_we` drops immediately.
- `display_en` rising in the same cycle as a request: SCAN wins, `wr_gnt=0`.
- `display_en` falling: a write may be granted in the same decision cycle. `pix_valid` keeps flushing the last 3 scan pixels.

## Test plan
- Scan only: `display_en=1` with (x,y)=(0,0),(639,0),(0,1),(639,479) → `mem_addr` = 0, 639, 640, 307199 one cycle later. `pix_data`/`pix_valid` echo RAM contents 3 cycles later. `wr_gnt=0` throughout.
- Both clients requesting during blanking, client0 addr 100 data 0xAA, client1 addr 200 data 0x55:
  - Grants go 0,1,0,1 on consecutive cycles (while each client holds its request).
  - `mem_we=1` with matching addr/data.
- Single client holding `wr_req` for 6 blanking cycles → grants on cycles 1,3,5. No back-to-back double write.
- Request at addr 307200 during blanking → `wr_gnt` pulses, `mem_we=0`, `drop_cnt` 0→1. Repeat 300 times → `drop_cnt` saturates at 255.
- Client0 requesting when `display_en` rises → no grant through the active region. Granted on the first blanking cycle; RAM is not written during the active region.
- Assert reset mid-write (`mem_we=1`, `rr_ptr=1`) → all outputs 0 immediately, asynchronously. After release, both clients requesting → client0 granted first.
